// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer.
// Defining COMMIT_TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp.
package commit_trace_buffer_pkg;

   localparam int unsigned TRACE_DEPTH  = 16;
   localparam int unsigned TRACE_VLEN   = 32;
   localparam int unsigned TRACE_XLEN   = 32;
   localparam int unsigned TRACE_TIME_W = 32;

   typedef enum logic {
      TRACE_INSN = 1'b0,
      TRACE_TRAP = 1'b1
   } trace_kind_e;

   // Stored field widths are fixed here; the top converts its ports to them.
   typedef struct packed {
      trace_kind_e             kind;
      logic [TRACE_VLEN-1:0]   pc;
      logic [4:0]              rd;
      logic                    we;
      logic [TRACE_XLEN-1:0]   data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      logic [TRACE_TIME_W-1:0] tstamp;
`endif
   } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_arbiter.sv
// Combinational push arbiter: grants requests in priority order (low index
// first) while free slots remain and reports accepted/dropped counts.
module trace_push_arbiter #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned CNT_W = 5
) (
   input  logic [NREQ-1:0]      req_i,
   input  logic [CNT_W-1:0]     free_i,
   output logic [NREQ-1:0]      accept_o,
   output logic [NREQ-1:0][1:0] offset_o,
   output logic [1:0]           accept_cnt_o,
   output logic [1:0]           drop_cnt_o
);

   logic [1:0] taken;
   logic [1:0] dropped;

   always_comb begin
      accept_o = '0;
      offset_o = '0;
      taken    = '0;
      dropped  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_i[i]) begin
            if (CNT_W'(taken) < free_i) begin
               accept_o[i] = 1'b1;
               offset_o[i] = taken;
               taken       = taken + 2'd1;
            end else begin
               dropped = dropped + 2'd1;
            end
         end
      end
      accept_cnt_o = taken;
      drop_cnt_o   = dropped;
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace FIFO fed by the commit stage and drained by a slow consumer.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (adds trace_time_o).
module commit_trace_buffer
   import commit_trace_buffer_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned DEPTH           = TRACE_DEPTH,
   parameter int unsigned VLEN            = TRACE_VLEN,
   parameter int unsigned XLEN            = TRACE_XLEN,
   parameter int unsigned DROP_CNT_W      = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 enable_i,
   input  logic                                 flush_i,
   input  logic                                 clear_i,
   input  logic [NR_COMMIT_PORTS-1:0]           commit_ack_i,
   input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] commit_pc_i,
   input  logic [NR_COMMIT_PORTS-1:0][4:0]      commit_rd_i,
   input  logic [NR_COMMIT_PORTS-1:0]           commit_we_i,
   input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0] commit_wdata_i,
   input  logic                                 exception_valid_i,
   input  logic [XLEN-1:0]                      exception_cause_i,
   input  logic [VLEN-1:0]                      exception_pc_i,
   output logic                                 trace_valid_o,
   input  logic                                 trace_ready_i,
   output logic                                 trace_kind_o,
   output logic [VLEN-1:0]                      trace_pc_o,
   output logic [4:0]                           trace_rd_o,
   output logic                                 trace_we_o,
   output logic [XLEN-1:0]                      trace_data_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   output logic [TRACE_TIME_W-1:0]              trace_time_o,
`endif
   output logic [DROP_CNT_W-1:0]                drop_cnt_o,
   output logic                                 overflow_o
);

   localparam int unsigned NREQ  = NR_COMMIT_PORTS + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   trace_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic                  overflow_q, overflow_d;

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       accept;
   logic [NREQ-1:0][1:0]  offset;
   logic [1:0]            accept_cnt;
   logic [1:0]            drop_now;
   logic [1:0]            drops_eff;
   logic [CNT_W-1:0]      free_slots;
   logic                  pop;
   logic [DROP_CNT_W-1:0] drop_base;
   logic [DROP_CNT_W:0]   drop_sum;
   trace_entry_t          new_entry [NREQ];
   trace_entry_t          head;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [TRACE_TIME_W-1:0] time_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         time_q <= '0;
      end else begin
         time_q <= time_q + 1'b1;
      end
   end
`endif

   // Request slots are ordered port0, port1, ..., trap last.
   always_comb begin
      req = '0;
      for (int i = 0; i < NREQ; i++) begin
         new_entry[i] = '0;
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         req[i]            = enable_i & commit_ack_i[i];
         new_entry[i].kind = TRACE_INSN;
         new_entry[i].pc   = TRACE_VLEN'(commit_pc_i[i]);
         new_entry[i].rd   = commit_rd_i[i];
         new_entry[i].we   = commit_we_i[i];
         new_entry[i].data = TRACE_XLEN'(commit_wdata_i[i]);
      end
      req[NREQ-1]            = enable_i & exception_valid_i;
      new_entry[NREQ-1].kind = TRACE_TRAP;
      new_entry[NREQ-1].pc   = TRACE_VLEN'(exception_pc_i);
      new_entry[NREQ-1].data = TRACE_XLEN'(exception_cause_i);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      for (int i = 0; i < NREQ; i++) begin
         new_entry[i].tstamp = time_q;
      end
`endif
   end

   // Free space uses the registered count only, so ready never reaches accept.
   assign free_slots = DEPTH_C - count_q;
   assign pop        = (count_q != '0) && trace_ready_i;

   trace_push_arbiter #(
      .NREQ  (NREQ),
      .CNT_W (CNT_W)
   ) u_arbiter (
      .req_i        (req),
      .free_i       (free_slots),
      .accept_o     (accept),
      .offset_o     (offset),
      .accept_cnt_o (accept_cnt),
      .drop_cnt_o   (drop_now)
   );

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(accept_cnt);
         count_d  = count_q + CNT_W'(accept_cnt) - CNT_W'(pop);
      end
   end

   // Pushes discarded by a flush are not drops; a drop outranks a clear.
   always_comb begin
      drops_eff  = flush_i ? 2'd0 : drop_now;
      drop_base  = clear_i ? '0 : drop_cnt_q;
      drop_sum   = {1'b0, drop_base} + (DROP_CNT_W + 1)'(drops_eff);
      drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      overflow_d = (overflow_q & ~clear_i) | (drops_eff != 2'd0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (!flush_i) begin
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               mem_q[wr_ptr_q + PTR_W'(offset[i])] <= new_entry[i];
            end
         end
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign trace_valid_o = (count_q != '0);
   assign trace_kind_o  = head.kind;
   assign trace_pc_o    = VLEN'(head.pc);
   assign trace_rd_o    = head.rd;
   assign trace_we_o    = head.we;
   assign trace_data_o  = XLEN'(head.data);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   assign trace_time_o  = head.tstamp;
`endif
   assign drop_cnt_o    = drop_cnt_q;
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized self-checking bench for commit_trace_buffer against a queue model.
module tb_commit_trace_buffer;

   localparam int NR       = 2;
   localparam int DEPTH    = 16;
   localparam int DW       = 16;
   localparam int DROP_MAX = (1 << DW) - 1;

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
   } ent_t;

   logic                   clk_i;
   logic                   rst_ni;
   logic                   enable_i;
   logic                   flush_i;
   logic                   clear_i;
   logic [NR-1:0]          commit_ack_i;
   logic [NR-1:0][31:0]    commit_pc_i;
   logic [NR-1:0][4:0]     commit_rd_i;
   logic [NR-1:0]          commit_we_i;
   logic [NR-1:0][31:0]    commit_wdata_i;
   logic                   exception_valid_i;
   logic [31:0]            exception_cause_i;
   logic [31:0]            exception_pc_i;
   logic                   trace_valid_o;
   logic                   trace_ready_i;
   logic                   trace_kind_o;
   logic [31:0]            trace_pc_o;
   logic [4:0]             trace_rd_o;
   logic                   trace_we_o;
   logic [31:0]            trace_data_o;
   logic [DW-1:0]          drop_cnt_o;
   logic                   overflow_o;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [31:0]            trace_time_o;
`endif

   ent_t dutHead;
   ent_t mq[$];
   int   mdrop;
   logic movf;
   int   checks;
   int   errors;

   assign dutHead = {trace_kind_o, trace_pc_o, trace_rd_o, trace_we_o, trace_data_o};

   commit_trace_buffer #(
      .NR_COMMIT_PORTS (NR),
      .DEPTH           (DEPTH),
      .VLEN            (32),
      .XLEN            (32),
      .DROP_CNT_W      (DW)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .enable_i          (enable_i),
      .flush_i           (flush_i),
      .clear_i           (clear_i),
      .commit_ack_i      (commit_ack_i),
      .commit_pc_i       (commit_pc_i),
      .commit_rd_i       (commit_rd_i),
      .commit_we_i       (commit_we_i),
      .commit_wdata_i    (commit_wdata_i),
      .exception_valid_i (exception_valid_i),
      .exception_cause_i (exception_cause_i),
      .exception_pc_i    (exception_pc_i),
      .trace_valid_o     (trace_valid_o),
      .trace_ready_i     (trace_ready_i),
      .trace_kind_o      (trace_kind_o),
      .trace_pc_o        (trace_pc_o),
      .trace_rd_o        (trace_rd_o),
      .trace_we_o        (trace_we_o),
      .trace_data_o      (trace_data_o),
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      .trace_time_o      (trace_time_o),
`endif
      .drop_cnt_o        (drop_cnt_o),
      .overflow_o        (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Model one clock: gather requests, admit into free space seen before the pop,
   // then pop, then append; the rest are drops unless the cycle is flushed.
   task automatic step();
      ent_t reqs[$];
      ent_t e;
      int   nfree;
      int   nacc;
      int   ndrop;
      ndrop = 0;
      if (enable_i) begin
         for (int i = 0; i < NR; i++) begin
            if (commit_ack_i[i]) begin
               e.kind = 1'b0; e.pc = commit_pc_i[i]; e.rd = commit_rd_i[i];
               e.we = commit_we_i[i]; e.data = commit_wdata_i[i];
               reqs.push_back(e);
            end
         end
         if (exception_valid_i) begin
            e.kind = 1'b1; e.pc = exception_pc_i; e.rd = 5'd0;
            e.we = 1'b0; e.data = exception_cause_i;
            reqs.push_back(e);
         end
      end
      if (flush_i) begin
         mq.delete();
      end else begin
         nfree = DEPTH - mq.size();
         nacc  = (reqs.size() < nfree) ? reqs.size() : nfree;
         ndrop = reqs.size() - nacc;
         if (mq.size() != 0 && trace_ready_i) void'(mq.pop_front());
         for (int k = 0; k < nacc; k++) mq.push_back(reqs[k]);
      end
      if (clear_i) begin
         mdrop = 0;
         movf  = 1'b0;
      end
      if (ndrop > 0) begin
         mdrop = (mdrop + ndrop > DROP_MAX) ? DROP_MAX : mdrop + ndrop;
         movf  = 1'b1;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      enable_i          = 1'b1;
      flush_i           = 1'b0;
      clear_i           = 1'b0;
      commit_ack_i      = '0;
      exception_valid_i = 1'b0;
   endtask

   task automatic randPayload();
      for (int i = 0; i < NR; i++) begin
         commit_pc_i[i]    = $urandom;
         commit_rd_i[i]    = 5'($urandom);
         commit_we_i[i]    = 1'($urandom);
         commit_wdata_i[i] = $urandom;
      end
      exception_pc_i    = $urandom;
      exception_cause_i = $urandom;
   endtask

   task automatic fill(input int target);
      trace_ready_i = 1'b0;
      while (mq.size() < target) begin
         idle();
         randPayload();
         commit_ack_i = 2'b01;
         step();
      end
      idle();
   endtask

   task automatic flushClear();
      idle();
      flush_i = 1'b1;
      clear_i = 1'b1;
      step();
      idle();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      checks++;
      if ({trace_valid_o, dutHead} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_trace: got valid=%0b head=%h expected all zero", trace_valid_o, dutHead);
      end
      checks++;
      if ({drop_cnt_o, overflow_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_drop: got drop=%0d ovf=%0b expected 0/0", drop_cnt_o, overflow_o);
      end
      rst_ni = 1'b1;
      mq.delete();
      mdrop = 0;
      movf  = 1'b0;
   endtask

   task automatic test_single();
      idle();
      trace_ready_i     = 1'b1;
      commit_ack_i      = 2'b01;
      commit_pc_i[0]    = 32'h8000_0000;
      commit_rd_i[0]    = 5'd5;
      commit_we_i[0]    = 1'b1;
      commit_wdata_i[0] = 32'hDEAD_BEEF;
      step();
      idle();
      checks++;
      if (trace_valid_o !== 1'b1 || mq.size() != 1) begin
         errors++;
         $display("[TB] FAIL single_valid: got %0b expected 1 (model depth %0d)", trace_valid_o, mq.size());
      end
      checks++;
      if (dutHead !== {1'b0, 32'h8000_0000, 5'd5, 1'b1, 32'hDEAD_BEEF}) begin
         errors++;
         $display("[TB] FAIL single_head: got %h expected pc=80000000 rd=5 we=1 data=deadbeef", dutHead);
      end
      step();
      checks++;
      if (trace_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_pop: got valid=%0b expected 0", trace_valid_o);
      end
   endtask

   task automatic test_order();
      logic [31:0] expPc [3];
      expPc[0] = 32'h100; expPc[1] = 32'h104; expPc[2] = 32'h108;
      idle();
      randPayload();
      trace_ready_i     = 1'b0;
      commit_ack_i      = 2'b11;
      commit_pc_i[0]    = 32'h100;
      commit_pc_i[1]    = 32'h104;
      exception_valid_i = 1'b1;
      exception_pc_i    = 32'h108;
      exception_cause_i = 32'd2;
      step();
      idle();
      trace_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (trace_valid_o !== 1'b1 || trace_pc_o !== expPc[k] || trace_kind_o !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL order_entry%0d: got valid=%0b pc=%h kind=%0b expected 1/%h/%0b",
                     k, trace_valid_o, trace_pc_o, trace_kind_o, expPc[k], k == 2);
         end
         step();
      end
      checks++;
      if (trace_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL order_empty: got valid=%0b expected 0", trace_valid_o);
      end
   endtask

   task automatic test_overflow();
      flushClear();
      fill(DEPTH - 1);
      randPayload();
      commit_ack_i      = 2'b11;
      exception_valid_i = 1'b1;
      step();
      checks++;
      if (drop_cnt_o !== 16'd2 || overflow_o !== 1'b1 || mq.size() != DEPTH) begin
         errors++;
         $display("[TB] FAIL overflow_first: got drop=%0d ovf=%0b expected 2/1", drop_cnt_o, overflow_o);
      end
      randPayload();
      exception_valid_i = 1'b0;
      step();
      idle();
      checks++;
      if (drop_cnt_o !== 16'd4 || drop_cnt_o !== 16'(mdrop)) begin
         errors++;
         $display("[TB] FAIL overflow_second: got drop=%0d expected 4 (model %0d)", drop_cnt_o, mdrop);
      end
   endtask

   task automatic test_full_pop();
      int prevDrop;
      int pops;
      prevDrop      = mdrop;
      trace_ready_i = 1'b1;
      randPayload();
      commit_ack_i  = 2'b01;
      step();
      idle();
      checks++;
      if (drop_cnt_o !== 16'(prevDrop + 1)) begin
         errors++;
         $display("[TB] FAIL fullpop_drop: got %0d expected %0d", drop_cnt_o, prevDrop + 1);
      end
      pops = 0;
      while (trace_valid_o === 1'b1 && pops < 40) begin
         checks++;
         if (dutHead !== mq[0]) begin
            errors++;
            $display("[TB] FAIL fullpop_head: got %h expected %h", dutHead, mq[0]);
         end
         step();
         pops++;
      end
      checks++;
      if (pops != DEPTH - 1) begin
         errors++;
         $display("[TB] FAIL fullpop_count: got %0d entries expected %0d", pops, DEPTH - 1);
      end
   endtask

   task automatic test_flush_clear();
      flushClear();
      fill(DEPTH);
      randPayload();
      commit_ack_i      = 2'b11;
      exception_valid_i = 1'b1;
      step();
      idle();
      trace_ready_i = 1'b1;
      for (int k = 0; k < 9; k++) step();
      trace_ready_i = 1'b0;
      randPayload();
      flush_i      = 1'b1;
      commit_ack_i = 2'b01;
      step();
      idle();
      checks++;
      if (trace_valid_o !== 1'b0 || drop_cnt_o !== 16'd3 || overflow_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_state: got valid=%0b drop=%0d ovf=%0b expected 0/3/1",
                  trace_valid_o, drop_cnt_o, overflow_o);
      end
      clear_i = 1'b1;
      step();
      idle();
      checks++;
      if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_state: got drop=%0d ovf=%0b expected 0/0", drop_cnt_o, overflow_o);
      end
      fill(DEPTH);
      randPayload();
      clear_i      = 1'b1;
      commit_ack_i = 2'b11;
      step();
      idle();
      checks++;
      if (drop_cnt_o !== 16'd2 || overflow_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clear_vs_drop: got drop=%0d ovf=%0b expected 2/1", drop_cnt_o, overflow_o);
      end
   endtask

   task automatic test_reset_mid();
      flushClear();
      fill(9);
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({trace_valid_o, dutHead, drop_cnt_o, overflow_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got valid=%0b head=%h drop=%0d ovf=%0b expected all zero",
                  trace_valid_o, dutHead, drop_cnt_o, overflow_o);
      end
      mq.delete();
      mdrop = 0;
      movf  = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_saturation();
      flushClear();
      fill(DEPTH);
      commit_ack_i      = 2'b11;
      exception_valid_i = 1'b1;
      for (int k = 0; k < 23334; k++) step();
      idle();
      checks++;
      if (drop_cnt_o !== 16'hFFFF || overflow_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL saturation: got drop=%h ovf=%0b expected ffff/1", drop_cnt_o, overflow_o);
      end
   endtask

   task automatic test_random();
      flushClear();
      for (int c = 0; c < 3000; c++) begin
         randPayload();
         enable_i          = ($urandom_range(0, 7) != 0);
         flush_i           = ($urandom_range(0, 63) == 0);
         clear_i           = ($urandom_range(0, 31) == 0);
         commit_ack_i      = 2'($urandom);
         exception_valid_i = ($urandom_range(0, 3) == 0);
         trace_ready_i     = ($urandom_range(0, 2) == 0);
         step();
         checks++;
         if (trace_valid_o !== (mq.size() != 0)) begin
            errors++;
            $display("[TB] FAIL rand_valid c=%0d: got %0b expected %0b", c, trace_valid_o, mq.size() != 0);
         end
         if (mq.size() != 0) begin
            checks++;
            if (dutHead !== mq[0]) begin
               errors++;
               $display("[TB] FAIL rand_head c=%0d: got %h expected %h", c, dutHead, mq[0]);
            end
         end
         checks++;
         if (drop_cnt_o !== 16'(mdrop) || overflow_o !== movf) begin
            errors++;
            $display("[TB] FAIL rand_drop c=%0d: got drop=%0d ovf=%0b expected %0d/%0b",
                     c, drop_cnt_o, overflow_o, mdrop, movf);
         end
      end
      idle();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      clk_i         = 1'b0;
      trace_ready_i = 1'b0;
      idle();
      randPayload();
      test_reset();
      test_single();
      test_order();
      test_overflow();
      test_full_pop();
      test_flush_clear();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Retirement trace FIFO directly downstream of the commit stage.
- Each cycle it captures up to NR_COMMIT_PORTS retired instructions (PC, rd, write data) plus any trap taken at commit.
- It buffers them for a slow debug/monitor consumer over a valid/ready port.
- Commit is never back-pressured. On overflow, entries are dropped and counted.

Parameters:
- NR_COMMIT_PORTS, 2, commit ports observed (1 or 2)
- DEPTH, 16, FIFO entries; power of two, >=4
- VLEN, 32, PC width
- XLEN, 32, data/cause width
- DROP_CNT_W, 16, width of the saturating drop counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  capture enable; when low, no pushes
- flush_i  in  1  empties FIFO (synchronous)
- clear_i  in  1  clears drop counter and overflow flag
- commit_ack_i  in  NR_COMMIT_PORTS  port i retired this cycle
- commit_pc_i  in  NR_COMMIT_PORTS x VLEN  PC per port
- commit_rd_i  in  NR_COMMIT_PORTS x 5  destination register
- commit_we_i  in  NR_COMMIT_PORTS  GPR/FPR write performed
- commit_wdata_i  in  NR_COMMIT_PORTS x XLEN  written data
- exception_valid_i  in  1  trap taken at commit
- exception_cause_i  in  XLEN  trap cause
- exception_pc_i  in  VLEN  PC of trapping instruction
- trace_valid_o  out  1  head entry valid
- trace_ready_i  in  1  consumer accepts head
- trace_kind_o  out  1  0 = instruction, 1 = trap
- trace_pc_o  out  VLEN  entry PC
- trace_rd_o  out  5  rd (0 for trap)
- trace_we_o  out  1  write flag (0 for trap)
- trace_data_o  out  XLEN  wdata, or cause for a trap
- drop_cnt_o  out  DROP_CNT_W  entries dropped since clear
- overflow_o  out  1  sticky: at least one drop since clear

Behaviour:
- Reset (async, rst_ni low):
  - read pointer, write pointer and count are 0.
  - Storage is zeroed.
  - drop_cnt_o = 0 and overflow_o = 0.
  - All trace_* outputs are 0.
- Push request order within a cycle: port0 ack, port1 ack, trap. Up to NR_COMMIT_PORTS+1 requests per cycle, all gated by enable_i.
- Free slots are DEPTH - count, taken from the registered count before the cycle's pop. There is no same-cycle pass-through of a pop's freed slot, so there is no combinational path from ready to accept.
- Requests are accepted in priority order while free slots remain. The remainder are dropped.
- drop_cnt increments by the number dropped and saturates at all-ones. overflow is set if any request is dropped.
- Pop: when trace_valid_o && trace_ready_i, the read pointer advances. trace_valid_o = (count != 0).
- trace_* outputs are driven combinationally from the entry at the read pointer. The payload is held stable while valid && !ready.
- count_next = count + accepted - pop. Count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Entries pushed in the same cycle occupy consecutive slots in priority order.
- flush_i (highest priority over pushes and pops in that cycle): pointers and count go to 0. Pushes in that cycle are discarded and not counted as drops. drop_cnt and overflow are unaffected.
- clear_i: drop_cnt and overflow go to 0 next cycle. A drop in the same cycle as clear_i wins: drop_cnt = dropped count and overflow = 1.
- Empty with ready high: no pop, outputs remain those of the stale head slot, valid = 0.
- Full with 3 requests and a pop in the same cycle: all 3 are dropped, the pop proceeds, and count decrements by 1.

Optional Feature:
- COMMIT_TRACE_TIMESTAMP_EN defined:
  - An internal 32-bit free-running cycle counter runs, reset to 0 and wrapping.
  - Each entry stores the counter value at push.
  - An extra output trace_time_o (32 bits) is presented with the head entry.
  - The flush_i/clear_i semantics are unchanged by this feature.
- Undefined: no counter, no trace_time_o port, entry width reduced accordingly.

Decomposition:
- Shared package:
  - trace_kind_e enum (TRACE_INSN, TRACE_TRAP).
  - trace_entry_t struct (kind, pc, rd, we, data, optional time).
  - DEPTH default constant.
- One natural sub-module: trace_push_arbiter (combinational). It takes the request vector and free-slot count and produces the accepted mask, per-entry slot offsets and the drop count.
- The FIFO storage and pointers live in the top module.

Test Plan:
- Single push/pop:
  - Stimulus: ack0 = 1, pc = 0x8000_0000, rd = 5, we = 1, wdata = 0xDEAD_BEEF; ready = 1.
  - Response: next cycle valid = 1, kind = 0, pc/rd/data match, count = 1; after the pop, valid = 0.
- Dual commit plus trap ordering:
  - Stimulus: ack0 pc = 0x100, ack1 pc = 0x104, exception cause = 2 at pc = 0x108, all in one cycle; ready = 0.
  - Response: count = 3; with ready high, pops yield pc 0x100, 0x104, then a trap with data = 2.
- Overflow:
  - Stimulus: fill to DEPTH-1 (15); then push ack0 + ack1 + trap in one cycle.
  - Response: only ack0 accepted, count = 16, drop_cnt = 2, overflow = 1; a further dual push while full gives drop_cnt = 4.
- Full with simultaneous pop:
  - Stimulus: count = 16, ready = 1, ack0 = 1.
  - Response: the entry is dropped (no pass-through), count = 15, drop_cnt += 1.
- Flush vs clear:
  - Stimulus: count = 7, drop_cnt = 3; assert flush_i together with ack0.
  - Response: count = 0, valid = 0, drop_cnt stays 3. Then clear_i gives drop_cnt = 0, overflow = 0.
- Reset mid-operation and saturation:
  - Stimulus: assert rst_ni low asynchronously with count = 9.
  - Response: all outputs 0 immediately.
  - Separately: force 70000 drops with DROP_CNT_W = 16; drop_cnt holds at 0xFFFF.
